multi_dot_driver_core: RTL and testbench

//  Multi-channel successor to the single-dot driver path. Accepts timed firing commands
//  (channel, polarity, pulse width) over a valid/ready handshake. Drives CHANNELS H-bridge
//  p/n output pairs with per-channel inversion and an armed/disarmed safety qualifier.

---
 rtl/multi_dot_driver_core.sv | 180 ++++++++++++++++++
 tb/tb_multi_dot_driver_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dot_driver_core.sv
// Multi-channel H-bridge dot driver: armed handshake front end plus one pulse FSM per channel.
// Optional dead time on polarity reversal is compiled in with `define DEAD_TIME_EN.

module multi_dot_lane #(
   parameter int PULSE_W     = 8,
   parameter int DEAD_CYCLES = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               kill,
   input  logic               start,
   input  logic               data,
   input  logic [PULSE_W-1:0] width,
   output logic               busy,
   output logic               done,
   output logic [1:0]         pair
);

`ifdef DEAD_TIME_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DEAD = 2'd1, FIRE = 2'd2} state_t;
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   logic [DW-1:0] dcnt;
   logic          last_pol;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd2} state_t;
`endif

   state_t             state;
   logic [PULSE_W-1:0] cnt;
   logic               data_q;

   assign busy = (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= 1'b0;
         done   <= 1'b0;
         pair   <= 2'b00;
`ifdef DEAD_TIME_EN
         dcnt     <= '0;
         last_pol <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         // Disarm wins over everything, including a same-cycle accept: command is dropped silently.
         if (kill) begin
            state <= IDLE;
            pair  <= 2'b00;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     cnt    <= width;
                     data_q <= data;
                     if (width == '0) begin
                        done <= 1'b1;
                     end
`ifdef DEAD_TIME_EN
                     else if (data != last_pol) begin
                        state <= DEAD;
                        dcnt  <= DW'(DEAD_CYCLES);
                     end
`endif
                     else begin
                        state <= FIRE;
                        pair  <= {data, ~data};
`ifdef DEAD_TIME_EN
                        last_pol <= data;
`endif
                     end
                  end
               end
`ifdef DEAD_TIME_EN
               DEAD: begin
                  if (dcnt == DW'(1)) begin
                     state    <= FIRE;
                     pair     <= {data_q, ~data_q};
                     last_pol <= data_q;
                  end else begin
                     dcnt <= dcnt - 1'b1;
                  end
               end
`endif
               FIRE: begin
                  if (cnt == PULSE_W'(1)) begin
                     state <= IDLE;
                     pair  <= 2'b00;
                     done  <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  pair  <= 2'b00;
               end
            endcase
         end
      end
   end

endmodule

module multi_dot_driver_core #(
   parameter int CHANNELS    = 4,
   parameter int CH_ADDR_W   = 2,
   parameter int PULSE_W     = 8,
   parameter int ARM_CYCLES  = 4,
   parameter int DEAD_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [CH_ADDR_W-1:0]  cmd_channel,
   input  logic                  cmd_state,
   input  logic [PULSE_W-1:0]    cmd_width,
   input  logic                  output_active,
   input  logic [CHANNELS-1:0]   invert_mask,
   output logic                  armed,
   output logic [CHANNELS-1:0]   busy,
   output logic [CHANNELS-1:0]   done,
   output logic [2*CHANNELS-1:0] driver_io
);

   localparam int AW = $clog2(ARM_CYCLES + 1);

   if (ARM_CYCLES < 1 || DEAD_CYCLES < 1 || CH_ADDR_W < $clog2(CHANNELS)) begin : g_param_check
      $error("multi_dot_driver_core: illegal parameter combination");
   end

   logic [AW-1:0]       arm_cnt;
   logic                arm_next;
   logic                kill;
   logic                accept;
   logic [CHANNELS-1:0] sel;

   // armed rises on the edge that samples the ARM_CYCLES-th consecutive output_active.
   assign arm_next = output_active && (arm_cnt >= AW'(ARM_CYCLES - 1));
   assign kill     = ~arm_next;

   always_ff @(posedge clock) begin
      if (reset) begin
         arm_cnt <= '0;
         armed   <= 1'b0;
      end else begin
         armed <= arm_next;
         if (!output_active)
            arm_cnt <= '0;
         else if (arm_cnt != AW'(ARM_CYCLES))
            arm_cnt <= arm_cnt + 1'b1;
      end
   end

   // Out-of-range channels match no lane, so they are always ready and simply vanish.
   assign cmd_ready = armed & ~|(busy & sel);
   assign accept    = cmd_valid & cmd_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      assign sel[c] = (cmd_channel == CH_ADDR_W'(c));

      multi_dot_lane #(
         .PULSE_W     (PULSE_W),
         .DEAD_CYCLES (DEAD_CYCLES)
      ) u_lane (
         .clock (clock),
         .reset (reset),
         .kill  (kill),
         .start (accept & sel[c]),
         .data  (cmd_state ^ invert_mask[c]),
         .width (cmd_width),
         .busy  (busy[c]),
         .done  (done[c]),
         .pair  (driver_io[2*c +: 2])
      );
   end

endmodule

// File: tb/tb_multi_dot_driver_core.sv
// Bench for multi_dot_driver_core: directed scenarios then random traffic against a
// cycle-interval reference model (each command becomes busy/fire/done cycle ranges).

module tb_multi_dot_driver_core;

   localparam int CH   = 4;
   localparam int AW   = 3;
   localparam int PW   = 8;
   localparam int ARM  = 4;
   localparam int DEAD = 2;
`ifdef DEAD_TIME_EN
   localparam bit DEAD_EN = 1'b1;
`else
   localparam bit DEAD_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_state = 1'b0;
   logic          output_active = 1'b0;
   logic [AW-1:0] cmd_channel = '0;
   logic [PW-1:0] cmd_width = '0;
   logic [CH-1:0] invert_mask = '0;
   logic          cmd_ready, armed;
   logic [CH-1:0] busy, done;
   logic [2*CH-1:0] driver_io;

   always #5 clock = ~clock;

   multi_dot_driver_core #(
      .CHANNELS(CH), .CH_ADDR_W(AW), .PULSE_W(PW), .ARM_CYCLES(ARM), .DEAD_CYCLES(DEAD)
   ) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_channel(cmd_channel), .cmd_state(cmd_state), .cmd_width(cmd_width),
      .output_active(output_active), .invert_mask(invert_mask), .armed(armed),
      .busy(busy), .done(done), .driver_io(driver_io)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ones  = 0;
   bit m_armed;
   bit last_acc;
   int b_s[CH], b_e[CH], f_s[CH], f_e[CH], d_at[CH];
   bit pol[CH], lpol[CH], lp_prev[CH];

   function automatic void m_reset();
      for (int c = 0; c < CH; c++) begin
         b_s[c] = 0; b_e[c] = -1; f_s[c] = 0; f_e[c] = -1; d_at[c] = -1;
         pol[c] = 1'b0; lpol[c] = 1'b0; lp_prev[c] = 1'b0;
      end
      ones = 0;
      m_armed = 1'b0;
   endfunction

   function automatic bit in_rng(int x, int s, int e);
      return (x >= s) && (x <= e);
   endfunction

   function automatic bit m_ready();
      int ch;
      ch = int'(cmd_channel);
      if (!m_armed) return 1'b0;
      if (ch >= CH) return 1'b1;
      return !in_rng(cyc, b_s[ch], b_e[ch]);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Applies the inputs sampled at the edge that starts cycle cyc+1.
   task automatic model_edge();
      bit rdy, new_armed, d;
      int e, ch, w, dl;
      rdy = m_ready();
      e = cyc + 1;
      cyc = e;
      last_acc = 1'b0;
      if (reset) begin
         m_reset();
         return;
      end
      last_acc = cmd_valid && rdy;
      new_armed = output_active && (ones + 1 >= ARM);
      ones = output_active ? ((ones < 1000) ? ones + 1 : ones) : 0;
      if (!new_armed) begin
         for (int c = 0; c < CH; c++) begin
            if (f_s[c] >= e && f_e[c] >= f_s[c]) lpol[c] = lp_prev[c];
            if (b_e[c] >= e) b_e[c] = e - 1;
            if (f_e[c] >= e) f_e[c] = e - 1;
            if (d_at[c] >= e) d_at[c] = -1;
         end
      end else if (last_acc) begin
         ch = int'(cmd_channel);
         w  = int'(cmd_width);
         if (ch < CH) begin
            d = cmd_state ^ invert_mask[ch];
            if (w == 0) begin
               d_at[ch] = e; b_s[ch] = e; b_e[ch] = e - 1; f_s[ch] = e; f_e[ch] = e - 1;
            end else begin
               dl = (DEAD_EN && d != lpol[ch]) ? DEAD : 0;
               lp_prev[ch] = lpol[ch];
               b_s[ch] = e; b_e[ch] = e + dl + w - 1;
               f_s[ch] = e + dl; f_e[ch] = e + dl + w - 1;
               d_at[ch] = e + dl + w;
               pol[ch] = d; lpol[ch] = d;
            end
         end
      end
      m_armed = new_armed;
   endtask

   task automatic tick();
      logic [2*CH-1:0] e_io;
      logic [CH-1:0]   e_b, e_d;
      @(negedge clock);
      e_io = '0; e_b = '0; e_d = '0;
      for (int c = 0; c < CH; c++) begin
         e_b[c] = in_rng(cyc, b_s[c], b_e[c]);
         e_d[c] = (cyc == d_at[c]);
         if (in_rng(cyc, f_s[c], f_e[c])) begin
            e_io[2*c+1] = pol[c];
            e_io[2*c]   = ~pol[c];
         end
      end
      check("armed", 32'(armed), 32'(m_armed));
      check("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
      check("busy", 32'(busy), 32'(e_b));
      check("done", 32'(done), 32'(e_d));
      check("driver_io", 32'(driver_io), 32'(e_io));
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input int ch, input bit st, input int w, input logic [CH-1:0] mask);
      cmd_valid   = 1'b1;
      cmd_channel = AW'(ch);
      cmd_state   = st;
      cmd_width   = PW'(w);
      invert_mask = mask;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (last_acc) break;
      end
      n_cmp++;
      assert (last_acc) else begin
         n_bad++;
         $error("FAIL accept_timeout ch=%0d got=0 exp=1", ch);
      end
   endtask

   initial begin
      m_reset();
      @(posedge clock);
      m_reset();
      #1;
      idle(2);
      reset = 1'b0;

      // Too few active cycles to arm.
      output_active = 1'b1;
      idle(3);
      output_active = 1'b0;
      idle(3);

      // Arm, single pulse on ch1.
      output_active = 1'b1;
      idle(5);
      send(1, 1'b1, 5, 4'b0000);
      idle(8);

      // Inverted ch0, back-to-back command held valid.
      send(0, 1'b1, 3, 4'b0001);
      send(0, 1'b1, 2, 4'b0001);
      idle(5);

      // Long pulse killed by disarm.
      send(2, 1'b1, 200, 4'b0000);
      idle(49);
      output_active = 1'b0;
      idle(3);
      output_active = 1'b1;
      idle(5);

      // Overlapping channels, zero width, out-of-range channel.
      send(0, 1'b1, 4, 4'b0000);
      send(3, 1'b0, 4, 4'b0000);
      idle(6);
      send(1, 1'b1, 0, 4'b0000);
      send(5, 1'b1, 7, 4'b0000);
      idle(3);

      // Polarity reversal, then same-polarity repeat.
      send(0, 1'b1, 2, 4'b0000);
      send(0, 1'b0, 2, 4'b0000);
      send(0, 1'b0, 2, 4'b0000);
      idle(6);

      // Reset in the middle of a pulse.
      send(2, 1'b1, 10, 4'b0000);
      idle(3);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(6);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         cmd_valid     = 1'($urandom % 2);
         cmd_channel   = AW'($urandom_range(0, 5));
         cmd_state     = 1'($urandom % 2);
         cmd_width     = ($urandom % 8 == 0) ? PW'(0) : PW'($urandom_range(1, 12));
         invert_mask   = CH'($urandom);
         output_active = ($urandom % 80) != 0;
         tick();
      end
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
